fix_div_seq: RTL

//  Sequential signed fixed-point divider, the inverse of the fix_mul datapath.

---
 rtl/fix_div_seq.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fix_div_seq.sv
// Sequential signed fixed-point divider: quotient = (a <<< FRAC_BITS) / b, one restoring step per clock.
// Optional rounding (half away from zero) is enabled by defining FIX_DIV_ROUND_EN; default truncates.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | W restoring iterations, MSB first
// FIX   | magnitude -> signed result with saturation
// DONE  | result held until out_valid & out_ready
module fix_div_seq #(
    parameter int INT_BITS   = 12,
    parameter int FRAC_BITS  = 4,
    parameter int TOTAL_BITS = INT_BITS + FRAC_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [TOTAL_BITS-1:0] a,
    input  logic [TOTAL_BITS-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [TOTAL_BITS-1:0] quotient,
    output logic                  div_zero,
    output logic                  ovf
);

    localparam int W  = TOTAL_BITS + FRAC_BITS;
    localparam int CW = $clog2(W + 1);
    localparam int MSB = TOTAL_BITS - 1;

    localparam logic [TOTAL_BITS-1:0] MIN_V = {1'b1, {(TOTAL_BITS-1){1'b0}}};
    localparam logic [TOTAL_BITS-1:0] MAX_V = {1'b0, {(TOTAL_BITS-1){1'b1}}};
    localparam logic [W:0] MAG_MAX = {{(FRAC_BITS+1){1'b0}}, 1'b0, {(TOTAL_BITS-1){1'b1}}};
    localparam logic [W:0] MAG_MIN = {{(FRAC_BITS+1){1'b0}}, 1'b1, {(TOTAL_BITS-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                state_q;
    logic [W-1:0]          dvd_q;
    logic [W-1:0]          quo_q;
    logic [TOTAL_BITS-1:0] div_q;
    logic [TOTAL_BITS-1:0] rem_q;
    logic [CW-1:0]         cnt_q;
    logic                  sign_q;
    logic [TOTAL_BITS-1:0] quotient_q;
    logic                  div_zero_q;
    logic                  ovf_q;
    logic                  out_valid_q;

    logic [TOTAL_BITS-1:0] abs_a;
    logic [TOTAL_BITS-1:0] abs_b;
    logic [TOTAL_BITS:0]   rem_sh;
    logic                  trial_ge;
    logic [TOTAL_BITS-1:0] rem_sub;
    logic                  round_inc;
    logic [W:0]            mag_r;
    logic [TOTAL_BITS-1:0] mag_lo;
    logic [TOTAL_BITS-1:0] mag_neg;
    logic                  sat_pos;
    logic                  sat_neg;

    // |MIN| wraps to itself, which is the correct unsigned magnitude
    assign abs_a = a[MSB] ? -a : a;
    assign abs_b = b[MSB] ? -b : b;

    assign rem_sh   = {rem_q, dvd_q[W-1]};
    assign trial_ge = (rem_sh >= {1'b0, div_q});
    assign rem_sub  = rem_sh[TOTAL_BITS-1:0] - div_q;

`ifdef FIX_DIV_ROUND_EN
    assign round_inc = ({rem_q, 1'b0} >= {1'b0, div_q});
`else
    assign round_inc = 1'b0;
`endif

    assign mag_r   = {1'b0, quo_q} + {{W{1'b0}}, round_inc};
    assign mag_lo  = mag_r[TOTAL_BITS-1:0];
    assign mag_neg = -mag_lo;
    assign sat_pos = !sign_q && (mag_r > MAG_MAX);
    assign sat_neg = sign_q && (mag_r > MAG_MIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            quotient_q  <= '0;
            div_zero_q  <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q <= a[MSB] ^ b[MSB];
                        dvd_q  <= {abs_a, {FRAC_BITS{1'b0}}};
                        div_q  <= abs_b;
                        rem_q  <= '0;
                        quo_q  <= '0;
                        cnt_q  <= CW'(W - 1);
                        if (b == '0) begin
                            quotient_q <= a[MSB] ? MIN_V : MAX_V;
                            div_zero_q <= 1'b1;
                            ovf_q      <= 1'b0;
                            state_q    <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= trial_ge ? rem_sub : rem_sh[TOTAL_BITS-1:0];
                    quo_q <= {quo_q[W-2:0], trial_ge};
                    dvd_q <= {dvd_q[W-2:0], 1'b0};
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FIX: begin
                    div_zero_q <= 1'b0;
                    if (sat_pos) begin
                        quotient_q <= MAX_V;
                        ovf_q      <= 1'b1;
                    end else if (sat_neg) begin
                        quotient_q <= MIN_V;
                        ovf_q      <= 1'b1;
                    end else begin
                        quotient_q <= sign_q ? mag_neg : mag_lo;
                        ovf_q      <= 1'b0;
                    end
                    state_q <= DONE;
                end
                DONE: begin
                    // out_valid trails DONE entry by one edge; IDLE only after the handshake
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign div_zero  = div_zero_q;
    assign ovf       = ovf_q;

endmodule
